gate_resp_checker: RTL and testbench

- Self-checking response side for single-output gate tests.
- Accepts stimulus vectors from a generator through a valid/ready handshake.
- After each vector is accepted, waits a fixed settle time, samples the gate-under-test output and compares it with an expected truth table.
- Accumulates vector and error counts, then reports done/pass after the vector flagged last. Sits beside the gate under test, opposite the stimulus generator.

---
 rtl/gate_resp_checker.sv | 106 ++++++++++
 tb/tb_gate_resp_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// Response-side checker for single-output gate tests. It accepts a stimulus
// vector, waits SETTLE cycles, samples dut_y and scores it against the truth table TT.
module gate_resp_checker #(
   parameter int                      N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0]    TT     = 4'b1000,
   parameter int                      SETTLE = 20,
   parameter int                      CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stim_valid,
   input  logic [N_IN-1:0]  stim_vec,
   input  logic             stim_last,
   output logic             stim_ready,
   input  logic             dut_y,
   input  logic             clear,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [N_IN-1:0]  r_vec;
   logic             r_last;
   logic [CNT_W-1:0] r_vecCount;
   logic [CNT_W-1:0] r_errCount;
   logic [N_IN-1:0]  r_firstErrVec;
   logic             r_firstErrValid;
   logic             r_pass;

   logic             w_mismatch;
   logic [CNT_W-1:0] w_vecNext;
   logic [CNT_W-1:0] w_errNext;

   assign w_mismatch = (dut_y != TT[r_vec]);
   assign w_vecNext  = (&r_vecCount) ? r_vecCount : r_vecCount + CNT_W'(1);
   assign w_errNext  = (w_mismatch && !(&r_errCount)) ? r_errCount + CNT_W'(1) : r_errCount;

   // Leaving SETTLE when the counter reads 1 puts the sample edge exactly
   // SETTLE cycles after the acceptance edge.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_vec           <= '0;
         r_last          <= 1'b0;
         r_vecCount      <= '0;
         r_errCount      <= '0;
         r_firstErrVec   <= '0;
         r_firstErrValid <= 1'b0;
         r_pass          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (stim_valid) begin
                  r_vec   <= stim_vec;
                  r_last  <= stim_last;
                  r_cnt   <= SETTLE_M1;
                  r_state <= (SETTLE == 1) ? S_CHECK : S_SETTLE;
               end
            end
            S_SETTLE: begin
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt <= 8'd1) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               r_vecCount <= w_vecNext;
               r_errCount <= w_errNext;
               if (w_mismatch && !r_firstErrValid) begin
                  r_firstErrVec   <= r_vec;
                  r_firstErrValid <= 1'b1;
               end
               r_pass  <= r_last && (w_errNext == '0) && (w_vecNext != '0);
               r_state <= r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stim_ready      = (r_state == S_IDLE);
   assign busy            = (r_state == S_SETTLE) || (r_state == S_CHECK);
   assign done            = (r_state == S_DONE);
   assign pass            = r_pass;
   assign vec_count       = r_vecCount;
   assign err_count       = r_errCount;
   assign first_err_vec   = r_firstErrVec;
   assign first_err_valid = r_firstErrValid;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: a default AND checker (SETTLE=20) and an XOR checker
// (SETTLE=1, CNT_W=2), each scored against a transaction-level model of the run results.
module tb_gate_resp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic       rst_n;
   logic       clear[2];
   logic       valid[2];
   logic [1:0] vec[2];
   logic       last[2];
   logic       y[2];
   logic       ready[2];
   logic       busy[2];
   logic       done[2];
   logic       pass[2];
   logic [1:0] firstVec[2];
   logic       firstValid[2];
   logic [7:0] vecCnt0, errCnt0;
   logic [1:0] vecCnt1, errCnt1;

   gate_resp_checker #(.N_IN(2), .TT(4'b1000), .SETTLE(20), .CNT_W(8)) u_dutAnd (
      .clk(clk), .rst_n(rst_n), .stim_valid(valid[0]), .stim_vec(vec[0]),
      .stim_last(last[0]), .stim_ready(ready[0]), .dut_y(y[0]), .clear(clear[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .vec_count(vecCnt0),
      .err_count(errCnt0), .first_err_vec(firstVec[0]), .first_err_valid(firstValid[0])
   );

   gate_resp_checker #(.N_IN(2), .TT(4'b0110), .SETTLE(1), .CNT_W(2)) u_dutXor (
      .clk(clk), .rst_n(rst_n), .stim_valid(valid[1]), .stim_vec(vec[1]),
      .stim_last(last[1]), .stim_ready(ready[1]), .dut_y(y[1]), .clear(clear[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .vec_count(vecCnt1),
      .err_count(errCnt1), .first_err_vec(firstVec[1]), .first_err_valid(firstValid[1])
   );

   int         settleOf[2] = '{20, 1};
   logic [3:0] ttOf[2]     = '{4'b1000, 4'b0110};
   int         satMax[2]   = '{255, 3};

   // Reference model: run-level results only.
   int mVec[2];
   int mErr[2];
   int mFirstVec[2];
   int mFirstValid[2];
   int lastAccept[2];

   int nVectors    = 0;
   int nMiscompares = 0;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      nVectors++;
      if (obs != exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int vecCntOf(input int i);
      return (i == 0) ? int'(vecCnt0) : int'(vecCnt1);
   endfunction

   function automatic int errCntOf(input int i);
      return (i == 0) ? int'(errCnt0) : int'(errCnt1);
   endfunction

   function automatic int satInc(input int x, input int mx);
      return (x >= mx) ? mx : x + 1;
   endfunction

   task automatic resetModel(input int i);
      mVec[i] = 0; mErr[i] = 0; mFirstVec[i] = 0; mFirstValid[i] = 0;
   endtask

   // Modes: 0 correct, 1 wrong throughout, 2 wrong only on the sample cycle,
   // 3 wrong except on the sample cycle, 4 output stuck at 1. Called at a negedge.
   task automatic applyStimulus(input int i, input logic [1:0] v, input bit isLast,
                                input int mode, input bit checkSpacing);
      logic good, sampleVal, otherVal;
      int   waitCyc, lowCyc;
      good      = ttOf[i][v];
      sampleVal = (mode == 4) ? 1'b1 : ((mode == 1 || mode == 2) ? ~good : good);
      otherVal  = (mode == 4) ? 1'b1 : ((mode == 1 || mode == 3) ? ~good : good);
      valid[i] = 1'b1; vec[i] = v; last[i] = isLast; y[i] = otherVal;
      waitCyc = 0;
      while (!ready[i] && waitCyc < 50) begin
         @(negedge clk);
         waitCyc++;
      end
      if (!ready[i]) begin
         checkOutput("readyTimeout", 0, 1);
         valid[i] = 1'b0;
         return;
      end
      @(posedge clk);
      lowCyc = 0;
      for (int k = 1; k <= settleOf[i]; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (checkSpacing) checkOutput("acceptSpacing", cyc - lastAccept[i], settleOf[i] + 1);
            lastAccept[i] = cyc;
         end
         valid[i] = 1'b0;
         y[i] = (k == settleOf[i]) ? sampleVal : otherVal;
         if (!ready[i] && busy[i]) lowCyc++;
      end
      @(negedge clk);
      y[i] = good;
      checkOutput("readyLowCycles", lowCyc, settleOf[i]);
      mVec[i] = satInc(mVec[i], satMax[i]);
      if (sampleVal != good) begin
         mErr[i] = satInc(mErr[i], satMax[i]);
         if (mFirstValid[i] == 0) begin
            mFirstVec[i]   = int'(v);
            mFirstValid[i] = 1;
         end
      end
      checkOutput("vecCount", vecCntOf(i), mVec[i]);
      checkOutput("errCount", errCntOf(i), mErr[i]);
      if (isLast) begin
         checkOutput("doneAfterLast", int'(done[i]), 1);
         checkOutput("readyInDone", int'(ready[i]), 0);
      end else begin
         checkOutput("readyAfterVec", int'(ready[i]), 1);
      end
   endtask

   task automatic checkResults(input int i);
      checkOutput("done", int'(done[i]), 1);
      checkOutput("busyInDone", int'(busy[i]), 0);
      checkOutput("pass", int'(pass[i]), (mErr[i] == 0 && mVec[i] != 0) ? 1 : 0);
      checkOutput("finalVecCount", vecCntOf(i), mVec[i]);
      checkOutput("finalErrCount", errCntOf(i), mErr[i]);
      checkOutput("firstErrValid", int'(firstValid[i]), mFirstValid[i]);
      checkOutput("firstErrVec", int'(firstVec[i]), mFirstVec[i]);
   endtask

   task automatic checkReset(input int i);
      checkOutput("rstReady", int'(ready[i]), 1);
      checkOutput("rstBusy", int'(busy[i]), 0);
      checkOutput("rstDone", int'(done[i]), 0);
      checkOutput("rstPass", int'(pass[i]), 0);
      checkOutput("rstFirstValid", int'(firstValid[i]), 0);
      checkOutput("rstFirstVec", int'(firstVec[i]), 0);
      checkOutput("rstVecCount", vecCntOf(i), 0);
      checkOutput("rstErrCount", errCntOf(i), 0);
   endtask

   task automatic doClear(input int i);
      clear[i] = 1'b1;
      @(negedge clk);
      clear[i] = 1'b0;
      resetModel(i);
   endtask

   task automatic runVectors(input int i, input int mode, input int glitchVec);
      for (int v = 0; v < 4; v++) begin
         applyStimulus(i, 2'(v), v == 3, (v == glitchVec) ? 2 : mode, v != 0);
      end
   endtask

   initial begin
      int len, m;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         clear[i] = 1'b0; valid[i] = 1'b0; vec[i] = '0; last[i] = 1'b0; y[i] = 1'b0;
         resetModel(i); lastAccept[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkReset(0);
      checkReset(1);

      $display("[TB] AND gate, correct only on the sample cycle");
      runVectors(0, 3, -1);
      checkResults(0);
      doClear(0);
      checkReset(0);

      $display("[TB] AND gate, output stuck at 1");
      runVectors(0, 4, -1);
      checkResults(0);
      doClear(0);

      $display("[TB] XOR, SETTLE=1, back-to-back");
      runVectors(1, 0, -1);
      checkResults(1);
      doClear(1);

      $display("[TB] XOR, glitch on vector 10");
      runVectors(1, 0, 2);
      checkResults(1);
      doClear(1);

      $display("[TB] reset during settle of third vector");
      applyStimulus(0, 2'd0, 1'b0, 0, 1'b0);
      applyStimulus(0, 2'd1, 1'b0, 1, 1'b1);
      valid[0] = 1'b1; vec[0] = 2'd2; last[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      checkOutput("busyBeforeReset", int'(busy[0]), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      resetModel(0);
      resetModel(1);
      checkReset(0);
      runVectors(0, 0, -1);
      checkResults(0);
      doClear(0);

      $display("[TB] clear together with valid in IDLE");
      clear[0] = 1'b1; valid[0] = 1'b1; vec[0] = 2'd3; last[0] = 1'b1;
      @(negedge clk);
      clear[0] = 1'b0; valid[0] = 1'b0;
      @(negedge clk);
      checkOutput("clearBlocksReady", int'(ready[0]), 1);
      checkOutput("clearBlocksBusy", int'(busy[0]), 0);
      checkOutput("clearBlocksCount", vecCntOf(0), 0);

      $display("[TB] saturation with CNT_W=2");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 2'($urandom_range(0, 3)), k == 4, 1, k != 0);
      end
      checkResults(1);
      doClear(1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++) begin
         int i;
         i   = r % 2;
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            m = $urandom_range(0, 4);
            applyStimulus(i, 2'($urandom_range(0, 3)), k == len - 1, m, k != 0);
         end
         checkResults(i);
         doClear(i);
         checkOutput("clearDone", int'(done[i]), 0);
         checkOutput("clearReady", int'(ready[i]), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
